m_unit: RTL and testbench

Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Consumes the E/M pipeline registers (instruction, PC+4, ALU/HI/LO result, store data), performs word/halfword/byte stores into an internal data memory, and reads with sign/zero extension for loads. Latches the M/W pipeline registers and exports M-stage values for forwarding to the execute stage.

---
 rtl/m_unit.sv | 121 ++++++++++++
 tb/tb_m_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_unit.sv
// m_unit: MIPS memory stage; stores/loads against an internal data memory,
// latches M/W registers, exports M values for forwarding. Log macro: DM_STORE_LOG_EN.
// Ports:
//   Clk, Reset (async active-low)
//   IRM, PC4M, AOM, RTM, Forward_RT_M_src, W_RF_WD_OUT  (E/M inputs)
//   PC4_forw_M, AO  (combinational forwards to E)
//   IRW, PC4W, AOW, DRW  (M/W registers)
module m_unit #(
  parameter int DM_WORDS = 4096
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRM,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] RTM,
  input  logic        Forward_RT_M_src,
  input  logic [31:0] W_RF_WD_OUT,
  output logic [31:0] PC4_forw_M,
  output logic [31:0] AO,
  output logic [31:0] IRW,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [31:0]   mem [DM_WORDS];
  logic [AW-1:0] idx;
  logic [5:0]    op;
  logic [31:0]   wd;
  logic [31:0]   w;
  logic [31:0]   w_sh;
  logic [15:0]   half;
  logic [7:0]    byt;
  logic [31:0]   nw;
  logic [31:0]   ld;
  logic          we;

  assign PC4_forw_M = PC4M + 32'd4;
  assign AO         = AOM;

  // upper address bits are dropped: wraps modulo DM_WORDS
  assign idx  = AOM[AW+1:2];
  assign op   = IRM[31:26];
  assign wd   = Forward_RT_M_src ? W_RF_WD_OUT : RTM;
  assign w    = mem[idx];
  assign w_sh = w >> {AOM[1:0], 3'b000};
  assign byt  = w_sh[7:0];
  assign half = AOM[1] ? w[31:16] : w[15:0];

  always_comb begin
    we = 1'b0;
    nw = w;
    ld = '0;
    unique case (1'b1)
      (op == OP_SW): begin
        we = 1'b1;
        nw = wd;
      end
      (op == OP_SH): begin
        we = 1'b1;
        if (AOM[1]) nw[31:16] = wd[15:0];
        else        nw[15:0]  = wd[15:0];
      end
      (op == OP_SB): begin
        we = 1'b1;
        nw[{AOM[1:0], 3'b000} +: 8] = wd[7:0];
      end
      (op == OP_LW):  ld = w;
      (op == OP_LH):  ld = {{16{half[15]}}, half};
      (op == OP_LHU): ld = {16'h0, half};
      (op == OP_LB):  ld = {{24{byt[7]}}, byt};
      (op == OP_LBU): ld = {24'h0, byt};
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= nw;
    end
  end

  // IRM = 0 decodes as non-memory, so IRW/DRW load zero naturally
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IRW  <= '0;
      PC4W <= '0;
      AOW  <= '0;
      DRW  <= '0;
    end else begin
      IRW  <= IRM;
      PC4W <= PC4M;
      AOW  <= AOM;
      DRW  <= ld;
    end
  end

`ifdef DM_STORE_LOG_EN
  always_ff @(posedge Clk) begin
    if (Reset && we)
      $display("@%h: *%h <= %h", PC4M - 32'd4,
               {AOM[31:2], 2'b00}, nw);
  end
`endif

endmodule

// File: tb/tb_m_unit.sv
// tb_m_unit: directed self-checking bench for m_unit.
// One task per scenario; summary line counts checks and errors.
module tb_m_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IRM, PC4M, AOM, RTM, W_RF_WD_OUT;
  logic        Forward_RT_M_src;
  logic [31:0] PC4_forw_M, AO, IRW, PC4W, AOW, DRW;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;

  m_unit #(.DM_WORDS(4096)) dut (
    .Clk(Clk), .Reset(Reset),
    .IRM(IRM), .PC4M(PC4M), .AOM(AOM), .RTM(RTM),
    .Forward_RT_M_src(Forward_RT_M_src),
    .W_RF_WD_OUT(W_RF_WD_OUT),
    .PC4_forw_M(PC4_forw_M), .AO(AO),
    .IRW(IRW), .PC4W(PC4W), .AOW(AOW), .DRW(DRW)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] ir(input logic [5:0] op);
    return {op, 26'h0012345};
  endfunction

  // drive one M-stage instruction, let the edge pass, settle
  task automatic step(input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] d);
    IRM = i;
    AOM = a;
    RTM = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    IRM = '0; PC4M = 32'h1000; AOM = 32'h55; RTM = '0;
    Forward_RT_M_src = 1'b0; W_RF_WD_OUT = '0;
    #1;
    checks++;
    if (AO !== 32'h55) begin
      errors++;
      $display("FAIL reset_ao got %h exp %h", AO, 32'h55);
    end
    checks++;
    if (PC4_forw_M !== 32'h1004) begin
      errors++;
      $display("FAIL reset_pc4f got %h exp %h", PC4_forw_M, 32'h1004);
    end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({IRW, PC4W, AOW, DRW} !== 128'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h %h exp 0", IRW, PC4W, AOW, DRW);
    end
    Reset = 1'b1;
  endtask

  task automatic test_word;
    PC4M = 32'h3004;
    step(ir(SW), 32'h10, 32'h12345678);
    step(ir(LW), 32'h10, 32'h0);
    checks++;
    if (DRW !== 32'h12345678) begin
      errors++;
      $display("FAIL word_rt got %h exp %h", DRW, 32'h12345678);
    end
    checks++;
    if (IRW !== ir(LW) || AOW !== 32'h10 || PC4W !== 32'h3004) begin
      errors++;
      $display("FAIL word_wregs got %h %h %h exp %h %h %h",
               IRW, AOW, PC4W, ir(LW), 32'h10, 32'h3004);
    end
  endtask

  task automatic test_merge;
    step(ir(SW), 32'h20, 32'h0);
    step(ir(SB), 32'h23, 32'hFFFFFFAB);
    step(ir(SH), 32'h20, 32'h1234CDEF);
    step(ir(LW), 32'h20, 32'h0);
    checks++;
    if (DRW !== 32'hAB00CDEF) begin
      errors++;
      $display("FAIL merge got %h exp %h", DRW, 32'hAB00CDEF);
    end
    step(ir(SH), 32'h23, 32'h00001122);
    step(ir(LW), 32'h20, 32'h0);
    checks++;
    if (DRW !== 32'h1122CDEF) begin
      errors++;
      $display("FAIL merge_sh_hi got %h exp %h", DRW, 32'h1122CDEF);
    end
  endtask

  task automatic test_extend;
    logic [31:0] exp_v [5];
    logic [5:0]  ops   [5];
    logic [31:0] adr   [5];
    ops[0] = LB;  adr[0] = 32'h31; exp_v[0] = 32'h0000007F;
    ops[1] = LB;  adr[1] = 32'h33; exp_v[1] = 32'hFFFFFF80;
    ops[2] = LBU; adr[2] = 32'h33; exp_v[2] = 32'h00000080;
    ops[3] = LH;  adr[3] = 32'h32; exp_v[3] = 32'hFFFF80FF;
    ops[4] = LHU; adr[4] = 32'h32; exp_v[4] = 32'h000080FF;
    step(ir(SW), 32'h30, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      step(ir(ops[i]), adr[i], 32'h0);
      checks++;
      if (DRW !== exp_v[i]) begin
        errors++;
        $display("FAIL extend_%0d got %h exp %h", i, DRW, exp_v[i]);
      end
    end
  endtask

  task automatic test_forward;
    PC4M = 32'h3004;
    #1;
    checks++;
    if (PC4_forw_M !== 32'h3008) begin
      errors++;
      $display("FAIL fwd_pc4 got %h exp %h", PC4_forw_M, 32'h3008);
    end
    Forward_RT_M_src = 1'b1;
    W_RF_WD_OUT = 32'hDEADBEEF;
    step(ir(SW), 32'h40, 32'h0);
    Forward_RT_M_src = 1'b0;
    step(ir(LW), 32'h40, 32'h0);
    checks++;
    if (DRW !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fwd_store got %h exp %h", DRW, 32'hDEADBEEF);
    end
  endtask

  task automatic test_bubble_wrap;
    PC4M = 32'h0100;
    step(32'h0, 32'h10, 32'h55555555);
    checks++;
    if (IRW !== 32'h0 || DRW !== 32'h0) begin
      errors++;
      $display("FAIL bubble_zero got %h %h exp 0 0", IRW, DRW);
    end
    checks++;
    if (PC4W !== 32'h0100 || AOW !== 32'h10) begin
      errors++;
      $display("FAIL bubble_pass got %h %h exp %h %h",
               PC4W, AOW, 32'h0100, 32'h10);
    end
    step(ir(LW), 32'h10, 32'h0);
    checks++;
    if (DRW !== 32'h12345678) begin
      errors++;
      $display("FAIL bubble_mem got %h exp %h", DRW, 32'h12345678);
    end
    step(ir(SW), 32'h4010, 32'h0BADF00D);
    step(ir(LW), 32'h10, 32'h0);
    checks++;
    if (DRW !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL wrap got %h exp %h", DRW, 32'h0BADF00D);
    end
  endtask

  task automatic test_async_reset;
    // last step left nonzero W registers; store pending in M
    IRM = ir(SW); AOM = 32'h50; RTM = 32'h77777777;
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({IRW, PC4W, AOW, DRW} !== 128'h0) begin
      errors++;
      $display("FAIL areset_regs got %h %h %h %h exp 0", IRW, PC4W, AOW, DRW);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    step(ir(LW), 32'h10, 32'h0);
    checks++;
    if (DRW !== 32'h0) begin
      errors++;
      $display("FAIL areset_mem10 got %h exp 0", DRW);
    end
    step(ir(LW), 32'h50, 32'h0);
    checks++;
    if (DRW !== 32'h0) begin
      errors++;
      $display("FAIL areset_store_lost got %h exp 0", DRW);
    end
    step(ir(LW), 32'h40, 32'h0);
    checks++;
    if (DRW !== 32'h0) begin
      errors++;
      $display("FAIL areset_mem40 got %h exp 0", DRW);
    end
  endtask

  initial begin
    test_reset;
    @(posedge Clk);
    #1;
    test_word;
    test_merge;
    test_extend;
    test_forward;
    test_bubble_wrap;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
